// File: rtl/touch_button_if.sv
// Bundle between the touch-panel front end, the button table configuration
// and the GUI side of the touch button decoder.
interface touch_button_if #(
  parameter int N_BTN   = 16,
  parameter int COORD_W = 16,
  parameter int PAGE_W  = 3,
  parameter int IDX_W   = $clog2(N_BTN)
);
  logic               touch_valid;
  logic [COORD_W-1:0] touch_x;
  logic [COORD_W-1:0] touch_y;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic               cfg_en;
  logic [COORD_W-1:0] cfg_x0;
  logic [COORD_W-1:0] cfg_x1;
  logic [COORD_W-1:0] cfg_y0;
  logic [COORD_W-1:0] cfg_y1;
  logic [PAGE_W-1:0]  cfg_page;
  logic               cfg_nav;
  logic [PAGE_W-1:0]  cfg_target;
  logic               page_we;
  logic [PAGE_W-1:0]  page_din;
  logic [PAGE_W-1:0]  page;
  logic [N_BTN-1:0]   btn_press;
  logic [N_BTN-1:0]   btn_release;
  logic [N_BTN-1:0]   btn_long;
  logic [N_BTN-1:0]   btn_toggle;
  logic [IDX_W-1:0]   active_idx;
  logic               busy;

  modport master (
    output touch_valid, touch_x, touch_y,
    output cfg_we, cfg_idx, cfg_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1,
    output cfg_page, cfg_nav, cfg_target, page_we, page_din,
    input  page, btn_press, btn_release, btn_long, btn_toggle, active_idx, busy
  );

  modport slave (
    input  touch_valid, touch_x, touch_y,
    input  cfg_we, cfg_idx, cfg_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1,
    input  cfg_page, cfg_nav, cfg_target, page_we, page_din,
    output page, btn_press, btn_release, btn_long, btn_toggle, active_idx, busy
  );
endinterface

// File: rtl/touch_button_ctrl.sv
// Touch-panel button decoder: rectangular hit table, debounce, press/release/
// long-press pulses, per-button toggles and page navigation on release.
module touch_button_ctrl #(
  parameter int N_BTN       = 16,
  parameter int COORD_W     = 16,
  parameter int PAGE_W      = 3,
  parameter int DEB_CYCLES  = 4,
  parameter int REL_CYCLES  = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int IDX_W       = $clog2(N_BTN)
) (
  input  logic           clk,
  input  logic           reset,
  touch_button_if.slave  bus
);
  // state | meaning
  // IDLE     | no candidate, waiting for a hit
  // DEBOUNCE | counting consecutive hits on cand
  // PRESSED  | press reported, tracking hold time and release
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(REL_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST = RW'(REL_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] LONG_AT  = HW'(HOLD_CYCLES - DEB_CYCLES);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
    logic [PAGE_W-1:0]  pg;
    logic               nav;
    logic [PAGE_W-1:0]  tgt;
  } slot_t;

  slot_t            tbl_q [N_BTN];
  slot_t            tbl_d [N_BTN];
  state_t           state_q, state_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    off_q, off_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [N_BTN-1:0] press_q, press_d, rel_q, rel_d, long_q, long_d, tog_q, tog_d;

  logic [N_BTN-1:0] hit;
  logic             hit_any;
  logic [IDX_W-1:0] win;
  logic             abort_cfg;
  logic             on_cand;

  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    win     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hit[i] = bus.touch_valid && tbl_q[i].en &&
               (tbl_q[i].x0 <= bus.touch_x) && (bus.touch_x <= tbl_q[i].x1) &&
               (tbl_q[i].y0 <= bus.touch_y) && (bus.touch_y <= tbl_q[i].y1) &&
               ((tbl_q[i].pg == page_q) || (tbl_q[i].pg == '1));
    end
    // Descending scan so the lowest hitting index is the last one written.
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        win     = IDX_W'(i);
      end
    end
  end

  always_comb begin
    tbl_d    = tbl_q;
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    hold_d   = hold_q;
    page_d   = page_q;
    press_d  = '0;
    rel_d    = '0;
    long_d   = '0;
    tog_d    = tog_q;
    on_cand  = hit_any && (win == cand_q);
    abort_cfg = bus.cfg_we && (bus.cfg_idx == cand_q) && (state_q != IDLE);

    if (bus.cfg_we && (32'(bus.cfg_idx) < 32'(N_BTN))) begin
      tbl_d[bus.cfg_idx] = '{en: bus.cfg_en, x0: bus.cfg_x0, x1: bus.cfg_x1,
                             y0: bus.cfg_y0, y1: bus.cfg_y1, pg: bus.cfg_page,
                             nav: bus.cfg_nav, tgt: bus.cfg_target};
    end

    if (bus.page_we || abort_cfg) begin
      if (bus.page_we) page_d = bus.page_din;
      state_d = IDLE;
      cnt_d   = '0;
      off_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_any) begin
            cand_d = win;
            cnt_d  = DW'(1);
            off_d  = '0;
            hold_d = '0;
            if (DEB_CYCLES == 1) begin
              press_d[win] = 1'b1;
              state_d      = PRESSED;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!on_cand) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            press_d[cand_q] = 1'b1;
            state_d = PRESSED;
            cnt_d   = '0;
            off_d   = '0;
            hold_d  = '0;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        PRESSED: begin
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
          if (on_cand) begin
            off_d = '0;
          end else if (off_q == REL_LAST) begin
            off_d          = '0;
            rel_d[cand_q]  = 1'b1;
            tog_d[cand_q]  = ~tog_q[cand_q];
            state_d        = IDLE;
            if (tbl_q[cand_q].nav) page_d = tbl_q[cand_q].tgt;
          end else begin
            off_d = off_q + RW'(1);
          end
          // Long press and release of the same slot never share a cycle.
          if ((hold_d == LONG_AT) && (hold_q != LONG_AT) && !rel_d[cand_q])
            long_d[cand_q] = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) tbl_q[i] <= '0;
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      hold_q  <= '0;
      page_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      tog_q   <= '0;
    end else begin
      tbl_q   <= tbl_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      hold_q  <= hold_d;
      page_q  <= page_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      tog_q   <= tog_d;
    end
  end

  assign bus.page        = page_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = rel_q;
  assign bus.btn_long    = long_q;
  assign bus.btn_toggle  = tog_q;
  assign bus.active_idx  = cand_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_touch_button_ctrl.sv
// Directed bench for touch_button_ctrl: tap, glitch, overlap, navigation,
// long press, config abort and asynchronous reset scenarios.
module tb_touch_button_ctrl;
  localparam int HOLD = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] exp;

  always #5 clk = ~clk;

  touch_button_if #(.N_BTN(16), .COORD_W(16), .PAGE_W(3)) bus ();

  touch_button_ctrl #(
    .N_BTN(16), .COORD_W(16), .PAGE_W(3),
    .DEB_CYCLES(4), .REL_CYCLES(4), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_touch(input logic v, input int x, input int y);
    bus.touch_valid = v;
    bus.touch_x     = 16'(x);
    bus.touch_y     = 16'(y);
  endtask

  task automatic cfg_slot(input int idx, input int x0, input int x1, input int y0,
                          input int y1, input int pg, input logic nav, input int tgt);
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = 4'(idx);
    bus.cfg_en     = 1'b1;
    bus.cfg_x0     = 16'(x0);
    bus.cfg_x1     = 16'(x1);
    bus.cfg_y0     = 16'(y0);
    bus.cfg_y1     = 16'(y1);
    bus.cfg_page   = 3'(pg);
    bus.cfg_nav    = nav;
    bus.cfg_target = 3'(tgt);
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.page, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_toggle,
         bus.active_idx, bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset_state got page=%0d tog=%h idx=%0d busy=%b exp all zero",
               bus.page, bus.btn_toggle, bus.active_idx, bus.busy);
    end
  endtask

  task automatic test_basic_tap();
    cfg_slot(0, 100, 200, 100, 200, 0, 1'b0, 0);
    set_touch(1'b1, 150, 150);
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i == 4) ? 16'h0001 : 16'h0000;
      total++;
      if (bus.btn_press !== exp) begin
        bad++;
        $display("FAIL tap_press step=%0d got=%h exp=%h", i, bus.btn_press, exp);
      end
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL tap_busy got=%b exp=1", bus.busy);
    end
    set_touch(1'b0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 16'h0001 : 16'h0000;
      total++;
      if (bus.btn_release !== exp) begin
        bad++;
        $display("FAIL tap_release step=%0d got=%h exp=%h", i, bus.btn_release, exp);
      end
    end
    total++;
    if (bus.btn_toggle !== 16'h0001 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL tap_toggle got tog=%h busy=%b exp tog=0001 busy=0",
               bus.btn_toggle, bus.busy);
    end
  endtask

  task automatic test_glitch();
    for (int i = 1; i <= 8; i++) begin
      set_touch((i != 4 && i != 8), 150, 150);
      step();
      total++;
      if (bus.btn_press !== 16'h0000) begin
        bad++;
        $display("FAIL glitch_press step=%0d got=%h exp=0000", i, bus.btn_press);
      end
      if (i == 4 || i == 8) begin
        total++;
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL glitch_idle step=%0d got busy=%b exp=0", i, bus.busy);
        end
      end
    end
    total++;
    if (bus.btn_toggle !== 16'h0001) begin
      bad++;
      $display("FAIL glitch_toggle got=%h exp=0001", bus.btn_toggle);
    end
  endtask

  task automatic test_overlap();
    cfg_slot(5, 0, 100, 0, 100, 0, 1'b0, 0);
    cfg_slot(2, 40, 60, 40, 60, 0, 1'b0, 0);
    set_touch(1'b1, 50, 50);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 16'h0004 : 16'h0000;
      total++;
      if (bus.btn_press !== exp) begin
        bad++;
        $display("FAIL overlap_press step=%0d got=%h exp=%h", i, bus.btn_press, exp);
      end
    end
    total++;
    if (bus.active_idx !== 4'd2) begin
      bad++;
      $display("FAIL overlap_idx got=%0d exp=2", bus.active_idx);
    end
    set_touch(1'b0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 16'h0004 : 16'h0000;
      total++;
      if (bus.btn_release !== exp) begin
        bad++;
        $display("FAIL overlap_release step=%0d got=%h exp=%h", i, bus.btn_release, exp);
      end
    end
  endtask

  task automatic test_nav();
    cfg_slot(3, 300, 400, 300, 400, 0, 1'b1, 4);
    cfg_slot(7, 500, 600, 500, 600, 7, 1'b0, 0);
    set_touch(1'b1, 350, 350);
    repeat (4) step();
    set_touch(1'b0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (bus.page !== ((i == 4) ? 3'd4 : 3'd0) ||
          bus.btn_release !== ((i == 4) ? 16'h0008 : 16'h0000)) begin
        bad++;
        $display("FAIL nav_page step=%0d got page=%0d rel=%h", i, bus.page, bus.btn_release);
      end
    end
    set_touch(1'b1, 150, 150);
    for (int i = 1; i <= 5; i++) begin
      step();
      total++;
      if (bus.busy !== 1'b0 || bus.btn_press !== 16'h0000) begin
        bad++;
        $display("FAIL nav_offpage step=%0d got busy=%b press=%h exp 0", i,
                 bus.busy, bus.btn_press);
      end
    end
    set_touch(1'b1, 550, 550);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 16'h0080 : 16'h0000;
      total++;
      if (bus.btn_press !== exp) begin
        bad++;
        $display("FAIL nav_anypage step=%0d got=%h exp=%h", i, bus.btn_press, exp);
      end
    end
    set_touch(1'b0, 0, 0);
    repeat (4) step();
    bus.page_we  = 1'b1;
    bus.page_din = 3'd0;
    step();
    bus.page_we = 1'b0;
    total++;
    if (bus.page !== 3'd0) begin
      bad++;
      $display("FAIL page_load got=%0d exp=0", bus.page);
    end
  endtask

  task automatic test_long();
    int nlong = 0;
    int at = -1;
    logic [15:0] lv = '0;
    cfg_slot(1, 700, 800, 700, 800, 0, 1'b0, 0);
    set_touch(1'b1, 750, 750);
    for (int i = 1; i <= HOLD + 20; i++) begin
      step();
      if (bus.btn_long !== 16'h0000) begin
        nlong++;
        at = i;
        lv = bus.btn_long;
      end
    end
    total++;
    if (nlong != 1 || at != HOLD || lv !== 16'h0002) begin
      bad++;
      $display("FAIL long_pulse got count=%0d at=%0d vec=%h exp count=1 at=%0d vec=0002",
               nlong, at, lv, HOLD);
    end
    set_touch(1'b0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 16'h0002 : 16'h0000;
      total++;
      if (bus.btn_release !== exp) begin
        bad++;
        $display("FAIL long_release step=%0d got=%h exp=%h", i, bus.btn_release, exp);
      end
    end
  endtask

  task automatic test_cfg_abort();
    cfg_slot(6, 900, 950, 900, 950, 0, 1'b1, 2);
    set_touch(1'b1, 920, 920);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 16'h0040 : 16'h0000;
      total++;
      if (bus.btn_press !== exp) begin
        bad++;
        $display("FAIL abort_press step=%0d got=%h exp=%h", i, bus.btn_press, exp);
      end
    end
    set_touch(1'b0, 0, 0);
    repeat (3) step();
    // Fourth off sample coincides with the rewrite of the tracked slot.
    cfg_slot(6, 900, 950, 900, 950, 0, 1'b1, 2);
    total++;
    if (bus.busy !== 1'b0 || bus.btn_release !== 16'h0000 ||
        bus.btn_toggle[6] !== 1'b0 || bus.page !== 3'd0) begin
      bad++;
      $display("FAIL abort_cfg got busy=%b rel=%h tog6=%b page=%0d exp 0 0 0 0",
               bus.busy, bus.btn_release, bus.btn_toggle[6], bus.page);
    end
    cfg_slot(0, 100, 200, 100, 200, 0, 1'b0, 0);
    total++;
    if (bus.btn_toggle[0] !== 1'b1) begin
      bad++;
      $display("FAIL toggle_keep got=%b exp=1", bus.btn_toggle[0]);
    end
  endtask

  task automatic test_reset_mid();
    bus.page_we  = 1'b1;
    bus.page_din = 3'd5;
    step();
    bus.page_we = 1'b0;
    total++;
    if (bus.page !== 3'd5) begin
      bad++;
      $display("FAIL page_force got=%0d exp=5", bus.page);
    end
    set_touch(1'b1, 550, 550);
    repeat (4) step();
    total++;
    if (bus.busy !== 1'b1 || bus.active_idx !== 4'd7) begin
      bad++;
      $display("FAIL mid_pressed got busy=%b idx=%0d exp 1 7", bus.busy, bus.active_idx);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.page, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_toggle,
         bus.active_idx, bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid got page=%0d tog=%h idx=%0d busy=%b exp all zero",
               bus.page, bus.btn_toggle, bus.active_idx, bus.busy);
    end
    #2 reset = 1'b0;
    set_touch(1'b1, 150, 150);
    for (int i = 1; i <= 5; i++) begin
      step();
      total++;
      if (bus.btn_press !== 16'h0000 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_table step=%0d got press=%h busy=%b exp 0", i,
                 bus.btn_press, bus.busy);
      end
    end
    set_touch(1'b0, 0, 0);
  endtask

  initial begin
    set_touch(1'b0, 0, 0);
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_en     = 1'b0;
    bus.cfg_x0     = '0;
    bus.cfg_x1     = '0;
    bus.cfg_y0     = '0;
    bus.cfg_y1     = '0;
    bus.cfg_page   = '0;
    bus.cfg_nav    = 1'b0;
    bus.cfg_target = '0;
    bus.page_we    = 1'b0;
    bus.page_din   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_basic_tap();
    test_glitch();
    test_overlap();
    test_nav();
    test_long();
    test_cfg_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
